mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline and a single-port word memory; byte/halfword/word with sub-word read-merge-write.
// Optional MAU_FAULT_EN enables misalignment/range faults; otherwise misaligned addresses are force-aligned.
module mem_access_unit #(
  parameter int unsigned DMEM_WORDS = 599
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  output logic        dm_mem_write,
  output logic        dm_mem_read,
  input  logic [31:0] dm_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q, word_q;

  logic        accept;
  logic        req_fault;
  logic [31:0] req_addr_al;

  assign accept = (state_q == IDLE) && req_valid;

`ifdef MAU_FAULT_EN
  logic fault_q;

  always_comb begin
    req_addr_al = req_addr;
    req_fault   = ((req_size == 2'b01) && req_addr[0])
               || (req_size[1] && (req_addr[1:0] != 2'b00))
               || ({2'b00, req_addr[31:2]} >= DMEM_WORDS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= req_fault;
    end
  end

  assign resp_fault = (state_q == RESP) && fault_q;
`else
  // Without fault checking the low address bits are dropped to the access size.
  always_comb begin
    req_fault   = 1'b0;
    req_addr_al = req_addr;
    if (req_size[1]) begin
      req_addr_al[1:0] = 2'b00;
    end else if (req_size == 2'b01) begin
      req_addr_al[0] = 1'b0;
    end
  end

  assign resp_fault = 1'b0;
`endif

  logic [4:0]  lane_sh;
  logic [31:0] rd_sh, load_val, lane_mask, merged;

  assign lane_sh = {addr_q[1:0], 3'b000};

  always_comb begin
    rd_sh     = dm_read_data >> lane_sh;
    load_val  = dm_read_data;
    lane_mask = 32'hFFFF_FFFF;
    if (size_q == 2'b00) begin
      load_val  = {{24{~uns_q & rd_sh[7]}}, rd_sh[7:0]};
      lane_mask = 32'h0000_00FF << lane_sh;
    end else if (size_q == 2'b01) begin
      load_val  = {{16{~uns_q & rd_sh[15]}}, rd_sh[15:0]};
      lane_mask = 32'h0000_FFFF << lane_sh;
    end
    merged = (word_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  always_comb begin
    state_d       = state_q;
    dm_mem_read   = 1'b0;
    dm_mem_write  = 1'b0;
    dm_address    = 32'h0;
    dm_write_data = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        dm_address = {2'b00, addr_q[31:2]};
        if (!we_q) begin
          dm_mem_read = 1'b1;
          state_d     = RESP;
        end else if (size_q[1]) begin
          dm_mem_write  = 1'b1;
          dm_write_data = wdata_q;
          state_d       = RESP;
        end else begin
          // Sub-word store: read the word now, write the merged word next cycle.
          dm_mem_read = 1'b1;
          state_d     = MERGE_WR;
        end
      end
      MERGE_WR: begin
        dm_address    = {2'b00, addr_q[31:2]};
        dm_mem_write  = 1'b1;
        dm_write_data = merged;
        state_d       = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr_al;
        wdata_q <= req_wdata;
        rdata_q <= 32'h0;
      end
      if (state_q == ACCESS) begin
        if (!we_q) begin
          rdata_q <= load_val;
        end else if (!size_q[1]) begin
          word_q <= dm_read_data;
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: bench-side memory, request-level reference model, per-cycle compare process.
module tb_mem_access_unit;
  localparam int DW = 599;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] dm_address, dm_write_data, dm_read_data;
  logic        dm_mem_write, dm_mem_read;

  mem_access_unit #(.DMEM_WORDS(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_mem_write(dm_mem_write), .dm_mem_read(dm_mem_read), .dm_read_data(dm_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [DW];
  logic [31:0] ref_mem [DW];

  assign dm_read_data = (dm_address < 32'(DW)) ? mem[dm_address[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (dm_mem_write && (dm_address < 32'(DW))) mem[dm_address[9:0]] <= dm_write_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   busy_lo = 1;
  int   busy_hi = 0;

  // Request-level reference: what the unit must return, and what memory must hold afterwards.
  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int c);
    exp_t        e;
    int          nb, idx, off;
    logic [31:0] w, mask, val;
    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.fault = 1'b0;
    e.rdata = 32'h0;
`ifdef MAU_FAULT_EN
    if ((addr % nb) != 0 || (addr / 4) >= DW) e.fault = 1'b1;
`else
    addr = addr - (addr % nb);
`endif
    idx = int'(addr / 4);
    off = int'(addr % 4);
    if (e.fault) e.due = c + 1;
    else if (we && nb < 4) e.due = c + 3;
    else e.due = c + 2;
    if (!e.fault) begin
      w = ref_mem[idx];
      if (!we) begin
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        val  = (w >> (8 * off)) & mask;
        if (!uns && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
        e.rdata = val;
      end else begin
        for (int i = 0; i < nb; i++) w[8 * (off + i) +: 8] = wdata[8 * i +: 8];
        ref_mem[idx] = w;
      end
    end
    return e;
  endfunction

  // Per-cycle comparison against the model's schedule.
  always @(negedge clk) begin
    logic exp_v, rdy_exp;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      check("resp_missed", 32'(resp_valid), 32'd1);
      void'(exp_q.pop_front());
    end
    exp_v   = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    rdy_exp = !(cyc >= busy_lo && cyc <= busy_hi);
    check("resp_valid", 32'(resp_valid), 32'(exp_v));
    if (exp_v) begin
      check("resp_rdata", resp_rdata, exp_q[0].rdata);
      check("resp_fault", 32'(resp_fault), 32'(exp_q[0].fault));
      void'(exp_q.pop_front());
    end else begin
      check("resp_idle_zero", {resp_rdata[31:1], resp_rdata[0] | resp_fault}, 32'h0);
    end
    check("req_ready", 32'(req_ready), 32'(rdy_exp));
    if (rdy_exp) begin
      check("dm_idle", dm_address | dm_write_data | 32'(dm_mem_write) | 32'(dm_mem_read), 32'h0);
    end
    check("rd_wr_overlap", 32'(dm_mem_read & dm_mem_write), 32'h0);
  end

  // Called at posedge+#1 with the unit idle; returns at posedge+#1 with the unit idle again.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rdata, output logic got_fault);
    exp_t e;
    bit   seen;
    int   idx;
    e = model(we, size, uns, addr, wdata, cyc);
    exp_q.push_back(e);
    busy_lo = cyc + 1;
    busy_hi = e.due;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    if (e.fault) check("fault_no_dm_access", 32'(dm_mem_read | dm_mem_write), 32'h0);
    seen = 1'b0;
    got_rdata = 32'hx;
    got_fault = 1'bx;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (resp_valid) begin
        seen = 1'b1;
        got_rdata = resp_rdata;
        got_fault = resp_fault;
      end
      @(posedge clk); #1;
    end
    if (!seen) check("resp_timeout", 32'd0, 32'd1);
    idx = int'((addr / 4) % DW);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  logic [31:0] r;
  logic        f;

  initial begin
    for (int i = 0; i < DW; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    mem[5] = 32'h8899_AABB;
    mem[8] = 32'h0;
    for (int i = 0; i < DW; i++) ref_mem[i] = mem[i];

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #3;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_outputs", {resp_rdata | dm_address | dm_write_data}, 32'h0);
    check("rst_strobes", 32'({resp_valid, resp_fault, dm_mem_write, dm_mem_read}), 32'h0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, r, f); check("ld_b_0x15_s", r, 32'hFFFF_FFAA);
    do_req(1'b0, 2'd0, 1'b0, 32'h16, 32'h0, r, f); check("ld_b_0x16_s", r, 32'hFFFF_FF99);
    do_req(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, r, f); check("ld_h_0x16_u", r, 32'h0000_8899);
    do_req(1'b0, 2'd0, 1'b1, 32'h14, 32'h0, r, f); check("ld_b_0x14_u", r, 32'h0000_00BB);
    do_req(1'b0, 2'd0, 1'b0, 32'h17, 32'h0, r, f); check("ld_b_0x17_s", r, 32'hFFFF_FF88);
    do_req(1'b0, 2'd1, 1'b0, 32'h14, 32'h0, r, f); check("ld_h_0x14_s", r, 32'hFFFF_AABB);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, r, f); check("ld_w_0x14", r, 32'h8899_AABB);

    do_req(1'b1, 2'd0, 1'b0, 32'h14, 32'h0000_005A, r, f);
    check("st_b_word5", mem[5], 32'h8899_AA5A);
    check("st_rdata_zero", r, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'hDEAD_BEEF, r, f);
    check("st_h_word5", mem[5], 32'hBEEF_AA5A);
    do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, r, f); check("ld_h_beef_s", r, 32'hFFFF_BEEF);
    do_req(1'b1, 2'd0, 1'b0, 32'h27, 32'h0000_0177, r, f);
    check("st_b_off3", mem[9][31:24], 32'h77);

    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, r, f);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r, f); check("ld_w_0x20", r, 32'h1234_5678);
    do_req(1'b1, 2'd3, 1'b0, 32'h30, 32'hCAFE_F00D, r, f);
    do_req(1'b0, 2'd3, 1'b1, 32'h30, 32'h0, r, f); check("ld_sz3_0x30", r, 32'hCAFE_F00D);

`ifdef MAU_FAULT_EN
    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, r, f);
    check("flt_misalign", 32'(f), 32'd1); check("flt_misalign_rdata", r, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h960, 32'h0, r, f);
    check("flt_range", 32'(f), 32'd1);
    do_req(1'b1, 2'd1, 1'b0, 32'h15, 32'h1234, r, f);
    check("flt_half_odd", 32'(f), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h958, 32'h0, r, f);
    check("ld_last_word_ok", 32'(f), 32'd0);
`else
    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, r, f); check("align_ld_w", r, 32'h1234_5678);
    do_req(1'b1, 2'd1, 1'b0, 32'h15, 32'h0000_1234, r, f);
    check("align_st_h", mem[5], 32'hBEEF_1234);
    check("align_no_fault", 32'(f), 32'd0);
`endif

    // Sub-word store cut short by reset while the merged word is on the bus.
    busy_lo = cyc + 1;
    busy_hi = cyc + 3;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h14; req_wdata = 32'hC3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("merge_wr_strobe", 32'(dm_mem_write), 32'd1);
    check("merge_wr_data", dm_write_data, (ref_mem[5] & 32'hFFFF_FF00) | 32'h0000_00C3);
    rst_n = 1'b0;
    busy_hi = cyc - 1;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_write", 32'(dm_mem_write), 32'd0);
    check("rst_mid_resp", 32'(resp_valid), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_word5_kept", mem[5], ref_mem[5]);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, r, f);
`ifdef MAU_FAULT_EN
    check("post_rst_ld", r, 32'hBEEF_AA5A);
`else
    check("post_rst_ld", r, 32'hBEEF_1234);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
